// File: rtl/tohost_pkg.sv
// Shared types and defaults for the tohost pass/fail monitor.
package tohost_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_e;

    localparam logic [31:0] PASS_VALUE = 32'd1;

    localparam logic [31:0] TOHOST_ADDR_0 = 32'h8000_1000;
    localparam logic [31:0] TOHOST_ADDR_1 = 32'h8000_3000;
    localparam logic [31:0] TOHOST_ADDR_2 = 32'h8017_fffc;

    localparam int unsigned DEFAULT_NUM_ADDR = 3;
    localparam logic [DEFAULT_NUM_ADDR*32-1:0] DEFAULT_TOHOST_ADDRS =
        {TOHOST_ADDR_2, TOHOST_ADDR_1, TOHOST_ADDR_0};

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tohost_snoop.sv
// Combinational tohost address match across all data ports; lowest port index wins.
module tohost_snoop
    import tohost_pkg::*;
#(
    parameter int unsigned                NUM_PORTS    = 1,
    parameter int unsigned                NUM_ADDR     = DEFAULT_NUM_ADDR,
    parameter logic [NUM_ADDR*32-1:0]     TOHOST_ADDRS = DEFAULT_TOHOST_ADDRS,
    parameter int unsigned                IDX_W        = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0]    req,
    input  logic [NUM_PORTS-1:0]    we,
    input  logic [4*NUM_PORTS-1:0]  be,
    input  logic [32*NUM_PORTS-1:0] addr,
    input  logic [32*NUM_PORTS-1:0] wdata,
    output logic                    hit_v,
    output logic [IDX_W-1:0]        hit_idx,
    output logic [31:0]             hit_data
);

    logic [NUM_PORTS-1:0] addr_match;
    logic [NUM_PORTS-1:0] port_hit;

    always_comb begin
        addr_match = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            for (int unsigned a = 0; a < NUM_ADDR; a++) begin
                if (addr[32*p +: 32] == TOHOST_ADDRS[32*a +: 32]) begin
                    addr_match[p] = 1'b1;
                end
            end
        end
    end

    // Only full-word writes count; partial-byte stores to tohost are ignored.
    always_comb begin
        port_hit = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            port_hit[p] = req[p] & we[p] & (be[4*p +: 4] == 4'hf) & addr_match[p];
        end
    end

    always_comb begin
        hit_v    = 1'b0;
        hit_idx  = '0;
        hit_data = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (!hit_v && port_hit[p]) begin
                hit_v    = 1'b1;
                hit_idx  = IDX_W'(p);
                hit_data = wdata[32*p +: 32];
            end
        end
    end

endmodule

// File: rtl/tohost_monitor.sv
// Snoops core data ports for tohost writes and reports a sticky pass/fail/timeout verdict
// with the number of cycles spent running.
module tohost_monitor
    import tohost_pkg::*;
#(
    parameter int unsigned            NUM_PORTS    = 1,
    parameter int unsigned            NUM_ADDR     = DEFAULT_NUM_ADDR,
    parameter logic [NUM_ADDR*32-1:0] TOHOST_ADDRS = DEFAULT_TOHOST_ADDRS,
    parameter int unsigned            CNT_W        = 64,
    parameter logic [CNT_W-1:0]       TIMEOUT      = '0
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              clear,
    input  logic [NUM_PORTS-1:0]              req,
    input  logic [NUM_PORTS-1:0]              we,
    input  logic [4*NUM_PORTS-1:0]            be,
    input  logic [32*NUM_PORTS-1:0]           addr,
    input  logic [32*NUM_PORTS-1:0]           wdata,
    output logic                              done,
    output logic                              done_pulse,
    output logic                              passed,
    output logic                              failed,
    output logic                              timed_out,
    output logic [30:0]                       fail_code,
    output logic [idx_width(NUM_PORTS)-1:0]   hit_port,
    output logic [CNT_W-1:0]                  cycle_count
);

    localparam int unsigned IDX_W = idx_width(NUM_PORTS);

    logic             snoop_v;
    logic [IDX_W-1:0] snoop_idx;
    logic [31:0]      snoop_data;

    logic             s1_v;
    logic [IDX_W-1:0] s1_idx;
    logic [31:0]      s1_data;

    state_e state;

    tohost_snoop #(
        .NUM_PORTS    (NUM_PORTS),
        .NUM_ADDR     (NUM_ADDR),
        .TOHOST_ADDRS (TOHOST_ADDRS),
        .IDX_W        (IDX_W)
    ) u_snoop (
        .req      (req),
        .we       (we),
        .be       (be),
        .addr     (addr),
        .wdata    (wdata),
        .hit_v    (snoop_v),
        .hit_idx  (snoop_idx),
        .hit_data (snoop_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_RUN;
            s1_v        <= 1'b0;
            s1_idx      <= '0;
            s1_data     <= '0;
            cycle_count <= '0;
            done        <= 1'b0;
            done_pulse  <= 1'b0;
            passed      <= 1'b0;
            failed      <= 1'b0;
            timed_out   <= 1'b0;
            fail_code   <= '0;
            hit_port    <= '0;
        end else if (clear) begin
            state       <= ST_RUN;
            s1_v        <= 1'b0;
            s1_idx      <= '0;
            s1_data     <= '0;
            cycle_count <= '0;
            done        <= 1'b0;
            done_pulse  <= 1'b0;
            passed      <= 1'b0;
            failed      <= 1'b0;
            timed_out   <= 1'b0;
            fail_code   <= '0;
            hit_port    <= '0;
        end else begin
            s1_v       <= snoop_v;
            s1_idx     <= snoop_idx;
            s1_data    <= snoop_data;
            done_pulse <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                    // A nonzero hit takes priority over a watchdog expiry in the same cycle.
                    if (s1_v && s1_data == PASS_VALUE) begin
                        state      <= ST_PASS;
                        passed     <= 1'b1;
                        done       <= 1'b1;
                        done_pulse <= 1'b1;
                        hit_port   <= s1_idx;
                    end else if (s1_v && s1_data != '0) begin
                        state      <= ST_FAIL;
                        failed     <= 1'b1;
                        done       <= 1'b1;
                        done_pulse <= 1'b1;
                        fail_code  <= s1_data[31:1];
                        hit_port   <= s1_idx;
                    end else if (TIMEOUT != '0 && cycle_count == TIMEOUT - 1'b1) begin
                        state      <= ST_TIMEOUT;
                        timed_out  <= 1'b1;
                        done       <= 1'b1;
                        done_pulse <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed bench for tohost_monitor (two ports, 100-cycle watchdog) with a reference model.
module tb_tohost_monitor;

    localparam int unsigned     NP  = 2;
    localparam longint unsigned TMO = 100;

    logic              clk    = 1'b0;
    logic              resetn = 1'b0;
    logic              clear  = 1'b0;
    logic [NP-1:0]     req;
    logic [NP-1:0]     we;
    logic [4*NP-1:0]   be;
    logic [32*NP-1:0]  addr;
    logic [32*NP-1:0]  wdata;
    logic              done;
    logic              done_pulse;
    logic              passed;
    logic              failed;
    logic              timed_out;
    logic [30:0]       fail_code;
    logic [0:0]        hit_port;
    logic [63:0]       cycle_count;

    int n_cmp  = 0;
    int n_err  = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    tohost_monitor #(
        .NUM_PORTS    (NP),
        .NUM_ADDR     (3),
        .TOHOST_ADDRS ({32'h8017fffc, 32'h80003000, 32'h80001000}),
        .CNT_W        (64),
        .TIMEOUT      (64'd100)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .clear       (clear),
        .req         (req),
        .we          (we),
        .be          (be),
        .addr        (addr),
        .wdata       (wdata),
        .done        (done),
        .done_pulse  (done_pulse),
        .passed      (passed),
        .failed      (failed),
        .timed_out   (timed_out),
        .fail_code   (fail_code),
        .hit_port    (hit_port),
        .cycle_count (cycle_count)
    );

    // Reference model: verdict 0 = running, 1 = pass, 2 = fail, 3 = timeout.
    int              m_verdict = 0;
    bit              m_pend_v  = 1'b0;
    logic [31:0]     m_pend_d  = '0;
    int              m_pend_p  = 0;
    longint unsigned m_cnt     = 0;
    bit              m_pulse   = 1'b0;
    logic [30:0]     m_code    = '0;
    int              m_port    = 0;

    function automatic bit is_tohost(input logic [31:0] a);
        return a inside {32'h80001000, 32'h80003000, 32'h8017fffc};
    endfunction

    function automatic void find_hit(output bit v, output logic [31:0] d, output int p);
        v = 1'b0;
        d = '0;
        p = 0;
        for (int i = NP - 1; i >= 0; i--) begin
            if (req[i] && we[i] && be[4*i +: 4] == 4'hf && is_tohost(addr[32*i +: 32])) begin
                v = 1'b1;
                d = wdata[32*i +: 32];
                p = i;
            end
        end
    endfunction

    task automatic model_reset();
        m_verdict = 0;
        m_pend_v  = 1'b0;
        m_pend_d  = '0;
        m_pend_p  = 0;
        m_cnt     = 0;
        m_pulse   = 1'b0;
        m_code    = '0;
        m_port    = 0;
    endtask

    task automatic model_clock();
        bit          v;
        logic [31:0] d;
        int          p;
        find_hit(v, d, p);
        if (clear) begin
            model_reset();
        end else begin
            m_pulse = 1'b0;
            if (m_verdict == 0) begin
                m_cnt++;
                if (m_pend_v && m_pend_d == 32'd1) begin
                    m_verdict = 1;
                    m_port    = m_pend_p;
                    m_pulse   = 1'b1;
                end else if (m_pend_v && m_pend_d != 32'd0) begin
                    m_verdict = 2;
                    m_code    = m_pend_d[31:1];
                    m_port    = m_pend_p;
                    m_pulse   = 1'b1;
                end else if (m_cnt == TMO) begin
                    m_verdict = 3;
                    m_pulse   = 1'b1;
                end
            end
            m_pend_v = v;
            m_pend_d = d;
            m_pend_p = p;
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) model_reset();
        else         model_clock();
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("done",        64'(done),        64'(m_verdict != 0));
            check("done_pulse",  64'(done_pulse),  64'(m_pulse));
            check("passed",      64'(passed),      64'(m_verdict == 1));
            check("failed",      64'(failed),      64'(m_verdict == 2));
            check("timed_out",   64'(timed_out),   64'(m_verdict == 3));
            check("fail_code",   64'(fail_code),   64'(m_code));
            check("hit_port",    64'(hit_port),    64'(m_port));
            check("cycle_count", cycle_count,      m_cnt);
        end
    end

    task automatic idle();
        req   = '0;
        we    = '0;
        be    = '0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic drive(input int p, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req[p]         = r;
        we[p]          = w;
        be[4*p +: 4]   = b;
        addr[32*p +: 32]  = a;
        wdata[32*p +: 32] = d;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        idle();
        repeat (3) step();
        resetn = 1'b1;
        chk_en = 1'b1;
        check("reset_done",  64'(done),   64'd0);
        check("reset_count", cycle_count, 64'd0);

        // Pass on port 0, write presented before edge 10
        repeat (9) step();
        drive(0, 1'b1, 1'b1, 32'h80001000, 32'd1, 4'hf);
        step();
        idle();
        step();
        check("t1_passed", 64'(passed),     64'd1);
        check("t1_pulse",  64'(done_pulse), 64'd1);
        check("t1_count",  cycle_count,     64'd11);
        check("t1_code",   64'(fail_code),  64'd0);
        check("t1_port",   64'(hit_port),   64'd0);
        step();
        check("t1_pulse_once", 64'(done_pulse), 64'd0);
        check("t1_sticky",     64'(passed),     64'd1);

        // Fail code 3, later pass write ignored
        do_clear();
        drive(0, 1'b1, 1'b1, 32'h8017fffc, 32'h7, 4'hf);
        step();
        idle();
        step();
        check("t2_failed", 64'(failed),    64'd1);
        check("t2_code",   64'(fail_code), 64'd3);
        drive(0, 1'b1, 1'b1, 32'h80001000, 32'd1, 4'hf);
        step();
        idle();
        repeat (2) step();
        check("t2_still_failed", 64'(failed), 64'd1);
        check("t2_not_passed",   64'(passed), 64'd0);
        check("t2_code_kept",    64'(fail_code), 64'd3);

        // Non-hits: wrong address, partial bytes, zero value, missing req/we
        do_clear();
        drive(0, 1'b1, 1'b1, 32'h80001004, 32'd1, 4'hf);
        step();
        drive(0, 1'b1, 1'b1, 32'h80001000, 32'd1, 4'h3);
        step();
        drive(0, 1'b1, 1'b1, 32'h80003000, 32'd0, 4'hf);
        step();
        drive(1, 1'b1, 1'b0, 32'h80003000, 32'd1, 4'hf);
        step();
        drive(1, 1'b0, 1'b1, 32'h80003000, 32'd9, 4'hf);
        step();
        idle();
        repeat (2) step();
        check("t3_no_verdict", 64'(done),   64'd0);
        check("t3_count",      cycle_count, 64'd7);

        // Port 1 alone passes
        do_clear();
        drive(1, 1'b1, 1'b1, 32'h80003000, 32'd1, 4'hf);
        step();
        idle();
        step();
        check("t4_passed", 64'(passed),   64'd1);
        check("t4_port",   64'(hit_port), 64'd1);

        // Simultaneous hits: port 0 (value 5) beats port 1 (value 1)
        do_clear();
        drive(0, 1'b1, 1'b1, 32'h80001000, 32'd5, 4'hf);
        drive(1, 1'b1, 1'b1, 32'h80003000, 32'd1, 4'hf);
        step();
        idle();
        step();
        check("t5_failed", 64'(failed),    64'd1);
        check("t5_code",   64'(fail_code), 64'd2);
        check("t5_port",   64'(hit_port),  64'd0);

        // Watchdog expiry at edge 100
        do_clear();
        repeat (99) step();
        check("t6_pre_timeout", 64'(timed_out), 64'd0);
        check("t6_pre_count",   cycle_count,    64'd99);
        step();
        check("t6_timed_out", 64'(timed_out),  64'd1);
        check("t6_pulse",     64'(done_pulse), 64'd1);
        check("t6_count",     cycle_count,     64'd100);
        step();
        check("t6_frozen", cycle_count, 64'd100);

        // Hit in the same stage-2 cycle as the watchdog expiry wins
        do_clear();
        repeat (98) step();
        drive(0, 1'b1, 1'b1, 32'h80001000, 32'd1, 4'hf);
        step();
        idle();
        step();
        check("t7_passed",  64'(passed),    64'd1);
        check("t7_no_tmo",  64'(timed_out), 64'd0);
        check("t7_count",   cycle_count,    64'd100);

        // Clear in PASS restarts everything
        do_clear();
        check("t8_passed", 64'(passed), 64'd0);
        check("t8_done",   64'(done),   64'd0);
        check("t8_count",  cycle_count, 64'd0);
        step();
        check("t8_count1", cycle_count, 64'd1);

        // Clear overrides a hit sitting in stage 1
        drive(0, 1'b1, 1'b1, 32'h80001000, 32'd1, 4'hf);
        step();
        idle();
        do_clear();
        repeat (2) step();
        check("t9_no_verdict", 64'(done), 64'd0);

        // Async reset with a hit in stage 1
        drive(0, 1'b1, 1'b1, 32'h80001000, 32'd1, 4'hf);
        step();
        idle();
        #2 resetn = 1'b0;
        #1;
        check("t10_async_count", cycle_count,  64'd0);
        check("t10_async_done",  64'(done),    64'd0);
        step();
        resetn = 1'b1;
        repeat (2) step();
        check("t10_no_verdict", 64'(passed), 64'd0);
        check("t10_count",      cycle_count, 64'd2);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
